// File: rtl/sid_audio_i2s.sv
// sid_audio_i2s: box-decimates the SID filter output, rounds/saturates it to
// 16 bits and serializes it as Philips I2S (same word on both channels).
module sid_audio_i2s #(
    parameter int CLK_DIV    = 4,
    parameter int LOG2_DECIM = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [17:0] audio,
    input  logic        sample_stb,
    input  logic        mute,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        overrun,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_data
);
    localparam int             AW   = 18 + LOG2_DECIM;
    localparam int             CW   = (LOG2_DECIM == 0) ? 1 : LOG2_DECIM;
    localparam logic [CW-1:0]  CMAX = CW'((1 << LOG2_DECIM) - 1);
    localparam int             DW   = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DMAX = DW'(CLK_DIV - 1);

    logic signed [AW-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic [15:0]          r_hold;
    logic                 r_new;
    logic [15:0]          r_shreg;
    logic [DW-1:0]        r_div;
    logic [4:0]           r_slot;

    logic signed [AW-1:0] w_sum;
    logic signed [17:0]   w_avg;
    logic signed [18:0]   w_rnd;
    logic [15:0]          w_sat;
    logic                 w_wrap;
    logic                 w_fall;
    logic                 w_load;
    logic [4:0]           w_nslot;

    // Average, then round to 16 bits; the 19-bit intermediate keeps avg+2 from wrapping.
    assign w_sum   = r_acc + AW'($signed(audio));
    assign w_avg   = 18'(w_sum >>> LOG2_DECIM);
    assign w_rnd   = (19'(w_avg) + 19'sd2) >>> 2;
    assign w_wrap  = (r_div == DMAX);
    assign w_fall  = w_wrap & i2s_bclk;
    assign w_load  = w_fall & (r_slot == 5'd31);
    assign w_nslot = r_slot + 5'd1;

    // Clamp the rounded average into the signed 16-bit range.
    always_comb begin
        w_sat = w_rnd[15:0];
        if (w_rnd > 19'sd32767)
            w_sat = 16'h7FFF;
        else if (w_rnd < -19'sd32768)
            w_sat = 16'h8000;
    end

    // Decimator: accumulate 2^LOG2_DECIM strobes, emit the rounded mean on the last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (sample_stb) begin
                if (r_cnt == CMAX) begin
                    r_acc        <= '0;
                    r_cnt        <= '0;
                    sample_out   <= w_sat;
                    sample_valid <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    // Hold register between decimator and serializer; flags samples the serializer never took.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold  <= '0;
            r_new   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= sample_valid & r_new & ~w_load;
            if (sample_valid) begin
                r_hold <= sample_out;
                r_new  <= 1'b1;
            end else if (w_load) begin
                r_new  <= 1'b0;
            end
        end
    end

    // BCLK divider, slot counter and serializer; everything moves on BCLK falling events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div    <= '0;
            r_slot   <= 5'd31;
            r_shreg  <= '0;
            i2s_bclk <= 1'b0;
            i2s_lrck <= 1'b0;
            i2s_data <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_div    <= '0;
                i2s_bclk <= ~i2s_bclk;
            end else begin
                r_div    <= r_div + DW'(1);
            end
            if (w_fall) begin
                r_slot   <= w_nslot;
                i2s_lrck <= (w_nslot >= 5'd15) && (w_nslot <= 5'd30);
                if (w_load) begin
                    r_shreg  <= mute ? 16'h0000 : r_hold;
                    i2s_data <= mute ? 1'b0 : r_hold[15];
                end else begin
                    i2s_data <= r_shreg[~w_nslot[3:0]];
                end
            end
        end
    end
endmodule

// File: tb/tb_sid_audio_i2s.sv
// Directed bench for sid_audio_i2s: one instance with LOG2_DECIM=0/CLK_DIV=2
// for rounding, serializer, overrun, mute and reset; one with LOG2_DECIM=2 for averaging.
module tb_sid_audio_i2s;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mute;
    logic [17:0] a0, a2;
    logic        s0, s2;
    logic [15:0] so0, so2;
    logic        v0, v2, ov0, ov2, b0, b2, l0, l2, d0, d2;

    int n_chk  = 0;
    int n_fail = 0;
    bit tmo    = 1'b0;

    always #5 clk = ~clk;

    sid_audio_i2s #(.CLK_DIV(2), .LOG2_DECIM(0)) u0 (
        .clk(clk), .reset_n(rst_n), .audio(a0), .sample_stb(s0), .mute(mute),
        .sample_out(so0), .sample_valid(v0), .overrun(ov0),
        .i2s_bclk(b0), .i2s_lrck(l0), .i2s_data(d0));

    sid_audio_i2s #(.CLK_DIV(4), .LOG2_DECIM(2)) u2 (
        .clk(clk), .reset_n(rst_n), .audio(a2), .sample_stb(s2), .mute(mute),
        .sample_out(so2), .sample_valid(v2), .overrun(ov2),
        .i2s_bclk(b2), .i2s_lrck(l2), .i2s_data(d2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One strobe on u0; returns at the negedge where sample_valid should be high.
    task automatic stb0(input logic [17:0] a);
        @(negedge clk); a0 = a; s0 = 1'b1;
        @(negedge clk); s0 = 1'b0;
    endtask

    // Wait for the next BCLK rising edge of u0; n = clocks waited.
    task automatic bclk_rise(output int n);
        logic p;
        bit   hit;
        p = b0; n = 0; hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); n++;
            if (!p && b0) begin hit = 1'b1; break; end
            p = b0;
        end
        if (!hit) tmo = 1'b1;
    endtask

    task automatic lrck_fall();
        logic p;
        bit   hit;
        p = l0; hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (p && !l0) begin hit = 1'b1; break; end
            p = l0;
        end
        if (!hit) tmo = 1'b1;
    endtask

    // Capture slots 0..31 on BCLK rising. sync=1 aligns on LRCK fall first;
    // sync=0 continues right after a previous capture. Optionally drive mute at slot 5.
    task automatic cap(input bit sync, input bit mset, input bit mval,
                       output logic [15:0] lw, output logic [15:0] rw, output logic [31:0] lm);
        int n;
        lw = '0; rw = '0; lm = '0;
        if (sync) begin
            lrck_fall();
            bclk_rise(n);
        end
        for (int s = 0; s < 32; s++) begin
            bclk_rise(n);
            lm[s] = l0;
            if (s < 16) lw[15-s] = d0;
            else        rw[31-s] = d0;
            if (mset && s == 5) mute = mval;
        end
    endtask

    initial begin
        logic [15:0] lw, rw;
        logic [31:0] lm;
        int          n, novr;

        rst_n = 1'b0; mute = 1'b0; a0 = '0; a2 = '0; s0 = 1'b0; s2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_so0", so0, 16'h0);  chk("rst_v0", v0, 0);  chk("rst_ov0", ov0, 0);
        chk("rst_bclk", b0, 0);      chk("rst_lrck", l0, 0); chk("rst_data", d0, 0);
        chk("rst_so2", so2, 16'h0);  chk("rst_v2", v2, 0);  chk("rst_bclk2", b2, 0);
        rst_n = 1'b1;

        // Mean over 4 spaced strobes of 0x400 -> 0x0100, valid exactly 1 clk after the 4th
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); a2 = 18'h00400; s2 = 1'b1;
            @(negedge clk); s2 = 1'b0;
            if (i < 3) chk("mean_novalid", v2, 0);
            else begin
                chk("mean_valid", v2, 1);
                chk("mean_val", so2, 16'h0100);
            end
            @(negedge clk);
            if (i == 3) chk("mean_pulse1", v2, 0);
        end
        // Back-to-back strobes of -4 -> mean -4 -> rounds to -1
        @(negedge clk); a2 = 18'h3FFFC; s2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) chk("b2b_novalid", v2, 0);
        end
        s2 = 1'b0;
        chk("b2b_valid", v2, 1);
        chk("b2b_val", so2, 16'hFFFF);

        // Rounding and saturation with LOG2_DECIM=0
        stb0(18'h3FFFC); chk("neg4_valid", v0, 1); chk("neg4", so0, 16'hFFFF);
        stb0(18'h1FFFF); chk("satp", so0, 16'h7FFF);
        stb0(18'h20000); chk("satn", so0, 16'h8000);

        // Serializer: hold = 0xA5C3
        stb0(18'h2970C); chk("a5c3_val", so0, 16'hA5C3);
        repeat (4) @(negedge clk);
        cap(1'b1, 1'b0, 1'b0, lw, rw, lm);
        chk("ser_left", lw, 16'hA5C3);
        chk("ser_right", rw, 16'hA5C3);
        chk("ser_lrck", lm, 32'h7FFF8000);
        bclk_rise(n); bclk_rise(n);
        chk("bclk_period", n, 4);

        // Overrun: two samples inside one frame, second one wins
        lrck_fall();
        repeat (8) @(negedge clk);
        novr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov0) novr++;
            s0 = (i == 0) || (i == 3);
            a0 = (i == 0) ? 18'h048D0 : 18'h159E0;
        end
        s0 = 1'b0;
        chk("ovr_count", novr, 1);
        chk("ovr_last", so0, 16'h5678);
        cap(1'b1, 1'b0, 1'b0, lw, rw, lm);
        chk("ovr_left", lw, 16'h5678);
        chk("ovr_right", rw, 16'h5678);
        cap(1'b0, 1'b0, 1'b0, lw, rw, lm);
        chk("repeat_left", lw, 16'h5678);
        chk("repeat_right", rw, 16'h5678);

        // Mute mid-frame: current frame intact, next zero, cleared -> restored
        cap(1'b1, 1'b1, 1'b1, lw, rw, lm);
        chk("mute_cur_l", lw, 16'h5678);
        chk("mute_cur_r", rw, 16'h5678);
        cap(1'b0, 1'b1, 1'b0, lw, rw, lm);
        chk("mute_zero_l", lw, 16'h0000);
        chk("mute_zero_r", rw, 16'h0000);
        cap(1'b0, 1'b0, 1'b0, lw, rw, lm);
        chk("unmute_l", lw, 16'h5678);
        chk("unmute_r", rw, 16'h5678);

        // Reset during slot 20
        lrck_fall();
        bclk_rise(n);
        for (int s = 0; s <= 20; s++) bclk_rise(n);
        chk("slot20_lrck", l0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_bclk", b0, 0);   chk("arst_lrck", l0, 0); chk("arst_data", d0, 0);
        chk("arst_so0", so0, 16'h0); chk("arst_ov0", ov0, 0);
        chk("arst_so2", so2, 16'h0);
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        begin
            logic p;
            bit   hit;
            p = b0; hit = 1'b0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk); n++;
                if (p && !b0) begin hit = 1'b1; break; end
                p = b0;
            end
            if (!hit) tmo = 1'b1;
        end
        chk("first_fall_clks", n, 4);
        chk("first_fall_data", d0, 0);
        chk("first_fall_lrck", l0, 0);
        cap(1'b0, 1'b0, 1'b0, lw, rw, lm);
        chk("post_rst_l", lw, 16'h0000);
        chk("post_rst_r", rw, 16'h0000);
        chk("post_rst_lrck", lm, 32'h7FFF8000);

        chk("no_timeout", tmo, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
